// File: rtl/timer_pkg.sv
// Shared definitions for the round-timer controller: FSM encoding, BCD constants
// and the BCD-to-binary helper used by the optional low-time warning.
package timer_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      RUN    = 3'd2,
      PAUSED = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam logic [3:0] BCD_ZERO   = 4'd0;
   localparam logic [3:0] BCD_NINE   = 4'd9;
   localparam int         MAX_DIGITS = 4;

   // Narrower counts are zero-extended into the 16-bit argument by the caller.
   function automatic logic [13:0] bcd_to_bin(input logic [15:0] bcd);
      logic [13:0] acc;
      acc = '0;
      for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
         acc = acc * 14'd10 + 14'(bcd[4*i +: 4]);
      end
      return acc;
   endfunction

endpackage

// File: rtl/timer_ctrl_bcd_digit_dec.sv
// Combinational single-digit BCD decrement with borrow; one instance per digit
// in the timer_ctrl borrow chain.
module bcd_digit_dec
   import timer_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       borrow_in,
   output logic [3:0] next_digit,
   output logic       borrow_out
);

   always_comb begin
      next_digit = digit;
      borrow_out = 1'b0;
      if (borrow_in) begin
         if (digit == BCD_ZERO) begin
            next_digit = BCD_NINE;
            borrow_out = 1'b1;
         end else begin
            next_digit = digit - 4'd1;
         end
      end
   end

endmodule

// File: rtl/timer_ctrl.sv
// Round-timer countdown controller: preset load, prescaled BCD decrement, pause/abort
// and a one-cycle expiry strobe. Define TIMER_WARN_EN to enable the low-time warn output.
//
// state  | meaning
// IDLE   | stopped, count cleared
// LOAD   | one cycle: latch clamped preset, clear prescaler
// RUN    | prescaler advancing, count decrements every TICK_DIV cycles
// PAUSED | count and prescaler frozen while pause is high
// DONE   | count reached zero, expired strobed on entry
module timer_ctrl
   import timer_pkg::*;
#(
   parameter int DIGITS     = 2,
   parameter int TICK_DIV   = 50000000,
   parameter int WARN_LEVEL = 5
) (
   input  logic                clock,
   input  logic                rst,
   input  logic                start,
   input  logic                pause,
   input  logic                abort,
   input  logic [4*DIGITS-1:0] preset,
   output logic [4*DIGITS-1:0] time_bcd,
   output logic                running,
   output logic                expired,
   output logic                warn
);

   localparam int             PW       = $clog2(TICK_DIV);
   localparam logic [PW-1:0]  PRE_LAST = PW'(TICK_DIV - 1);

   state_t              state;
   logic [PW-1:0]       prescaler;
   logic [4*DIGITS-1:0] dec_bcd;
   logic [4*DIGITS-1:0] clamped;
   logic [DIGITS:0]     borrow;
   logic                underflow;
   logic                dec_zero;
   logic                warn_load;
   logic                warn_dec;

   assign borrow[0] = 1'b1;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit_dec u_dec (
         .digit      (time_bcd[4*g +: 4]),
         .borrow_in  (borrow[g]),
         .next_digit (dec_bcd[4*g +: 4]),
         .borrow_out (borrow[g+1])
      );
      assign clamped[4*g +: 4] = (preset[4*g +: 4] > BCD_NINE) ? BCD_NINE : preset[4*g +: 4];
   end

   // A borrow out of the top digit means the count was already zero; never wrap.
   assign underflow = borrow[DIGITS];
   assign dec_zero  = (dec_bcd == '0);

`ifdef TIMER_WARN_EN
   function automatic logic low_time(input logic [4*DIGITS-1:0] v);
      logic [13:0] b;
      b = bcd_to_bin(16'(v));
      return (b != 14'd0) && (b <= 14'(WARN_LEVEL));
   endfunction

   assign warn_load = low_time(clamped);
   assign warn_dec  = low_time(dec_bcd);
`else
   assign warn_load = 1'b0;
   assign warn_dec  = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (!rst) begin
         state     <= IDLE;
         time_bcd  <= '0;
         prescaler <= '0;
         running   <= 1'b0;
         expired   <= 1'b0;
         warn      <= 1'b0;
      end else begin
         expired <= 1'b0;
         if (abort) begin
            state     <= IDLE;
            time_bcd  <= '0;
            prescaler <= '0;
            running   <= 1'b0;
            warn      <= 1'b0;
         end else begin
            case (state)
               IDLE, DONE: begin
                  if (start) state <= LOAD;
               end
               LOAD: begin
                  time_bcd  <= clamped;
                  prescaler <= '0;
                  if (clamped == '0) begin
                     state   <= DONE;
                     expired <= 1'b1;
                     running <= 1'b0;
                     warn    <= 1'b0;
                  end else begin
                     state   <= RUN;
                     running <= 1'b1;
                     warn    <= warn_load;
                  end
               end
               RUN: begin
                  // A tick on the same cycle as pause wins; pause takes effect next cycle.
                  if (prescaler == PRE_LAST) begin
                     prescaler <= '0;
                     if (!underflow) time_bcd <= dec_bcd;
                     if (dec_zero || underflow) begin
                        state   <= DONE;
                        expired <= 1'b1;
                        running <= 1'b0;
                        warn    <= 1'b0;
                     end else begin
                        warn <= warn_dec;
                     end
                  end else if (pause) begin
                     state <= PAUSED;
                  end else begin
                     prescaler <= prescaler + PW'(1);
                  end
               end
               PAUSED: begin
                  if (!pause) state <= RUN;
               end
               default: begin
                  state   <= IDLE;
                  running <= 1'b0;
                  warn    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: directed scenarios followed by randomized runs,
// all compared every cycle against a binary-count reference model.
module tb_timer_ctrl;

   localparam int DIGITS     = 2;
   localparam int TICK_DIV   = 4;
   localparam int WARN_LEVEL = 5;
   localparam int W          = 4 * DIGITS;

   localparam int M_IDLE   = 0;
   localparam int M_LOAD   = 1;
   localparam int M_RUN    = 2;
   localparam int M_PAUSED = 3;
   localparam int M_DONE   = 4;

   logic         clock = 1'b0;
   logic         rst   = 1'b0;
   logic         start = 1'b0;
   logic         pause = 1'b0;
   logic         abort = 1'b0;
   logic [W-1:0] preset = '0;
   logic [W-1:0] time_bcd;
   logic         running;
   logic         expired;
   logic         warn;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: count kept as a plain integer, interval as cycles left.
   int m_mode = M_IDLE;
   int m_cnt  = 0;
   int m_left = TICK_DIV;
   bit m_exp  = 1'b0;

   always #5 clock = ~clock;

   timer_ctrl #(
      .DIGITS     (DIGITS),
      .TICK_DIV   (TICK_DIV),
      .WARN_LEVEL (WARN_LEVEL)
   ) dut (
      .clock    (clock),
      .rst      (rst),
      .start    (start),
      .pause    (pause),
      .abort    (abort),
      .preset   (preset),
      .time_bcd (time_bcd),
      .running  (running),
      .expired  (expired),
      .warn     (warn)
   );

   function automatic int clamp_val(input logic [W-1:0] p);
      int v = 0;
      int scale = 1;
      for (int i = 0; i < DIGITS; i++) begin
         int d;
         d = int'(p[4*i +: 4]);
         if (d > 9) d = 9;
         v += d * scale;
         scale *= 10;
      end
      return v;
   endfunction

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r = '0;
      int x = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic model_step();
      m_exp = 1'b0;
      if (!rst) begin
         m_mode = M_IDLE;
         m_cnt  = 0;
         m_left = TICK_DIV;
      end else if (abort) begin
         m_mode = M_IDLE;
         m_cnt  = 0;
         m_left = TICK_DIV;
      end else if (m_mode == M_IDLE || m_mode == M_DONE) begin
         if (start) m_mode = M_LOAD;
      end else if (m_mode == M_LOAD) begin
         m_cnt  = clamp_val(preset);
         m_left = TICK_DIV;
         if (m_cnt == 0) begin
            m_mode = M_DONE;
            m_exp  = 1'b1;
         end else begin
            m_mode = M_RUN;
         end
      end else if (m_mode == M_RUN) begin
         if (m_left == 1) begin
            m_left = TICK_DIV;
            m_cnt  = m_cnt - 1;
            if (m_cnt == 0) begin
               m_mode = M_DONE;
               m_exp  = 1'b1;
            end
         end else if (pause) begin
            m_mode = M_PAUSED;
         end else begin
            m_left = m_left - 1;
         end
      end else if (m_mode == M_PAUSED) begin
         if (!pause) m_mode = M_RUN;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      bit  exp_run;
      bit  exp_warn;
      exp_run  = (m_mode == M_RUN) || (m_mode == M_PAUSED);
      exp_warn = 1'b0;
`ifdef TIMER_WARN_EN
      exp_warn = exp_run && (m_cnt != 0) && (m_cnt <= WARN_LEVEL);
`endif
      chk("model_time_bcd", 32'(time_bcd), 32'(to_bcd(m_cnt)));
      chk("model_running",  32'(running),  32'(exp_run));
      chk("model_expired",  32'(expired),  32'(m_exp));
      chk("model_warn",     32'(warn),     32'(exp_warn));
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      #1;
      check_all();
   endtask

   initial begin
      int n;

      // Reset
      rst = 1'b0;
      repeat (3) tick();
      chk("reset_time", 32'(time_bcd), 32'h0);
      chk("reset_running", 32'(running), 32'h0);
      chk("reset_expired", 32'(expired), 32'h0);
      chk("reset_warn", 32'(warn), 32'h0);
      rst = 1'b1;
      tick();

      // Full countdown from 12
      preset = 8'h12;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t1_load_running", 32'(running), 32'h0);
      tick();
      chk("t1_loaded", 32'(time_bcd), 32'h12);
      chk("t1_running", 32'(running), 32'h1);
      repeat (4) tick();
      chk("t1_after4", 32'(time_bcd), 32'h11);
      repeat (8) tick();
      chk("t1_after12", 32'(time_bcd), 32'h09);
      repeat (35) tick();
      chk("t1_pre_expire", 32'(expired), 32'h0);
      tick();
      chk("t1_expired", 32'(expired), 32'h1);
      chk("t1_zero", 32'(time_bcd), 32'h0);
      chk("t1_not_running", 32'(running), 32'h0);
      tick();
      chk("t1_expired_1cyc", 32'(expired), 32'h0);
      repeat (5) tick();
      chk("t1_zero_held", 32'(time_bcd), 32'h0);

      // Zero preset expires straight out of LOAD
      preset = 8'h00;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t2_load_running", 32'(running), 32'h0);
      tick();
      chk("t2_expired", 32'(expired), 32'h1);
      chk("t2_running", 32'(running), 32'h0);
      tick();
      chk("t2_expired_1cyc", 32'(expired), 32'h0);

      // Pause mid-interval
      preset = 8'h05;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      pause = 1'b1;
      repeat (10) tick();
      chk("t3_frozen", 32'(time_bcd), 32'h05);
      chk("t3_paused_running", 32'(running), 32'h1);
      pause = 1'b0;
      tick();
      tick();
      chk("t3_not_yet", 32'(time_bcd), 32'h05);
      tick();
      chk("t3_decrement", 32'(time_bcd), 32'h04);
      abort = 1'b1;
      tick();
      abort = 1'b0;

      // Abort beats start
      preset = 8'h07;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("t4_count", 32'(time_bcd), 32'h07);
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      chk("t4_time", 32'(time_bcd), 32'h0);
      chk("t4_running", 32'(running), 32'h0);
      chk("t4_expired", 32'(expired), 32'h0);
      repeat (3) tick();
      chk("t4_idle_running", 32'(running), 32'h0);

      // Clamp, ignored restart, mid-run reset
      preset = 8'h3F;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("t5_clamped", 32'(time_bcd), 32'h39);
      repeat (5) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t5_restart_ignored", 32'(time_bcd), 32'h38);
      chk("t5_still_running", 32'(running), 32'h1);
      tick();
      tick();
      chk("t5_continues", 32'(time_bcd), 32'h37);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("t5_rst_time", 32'(time_bcd), 32'h0);
      chk("t5_rst_running", 32'(running), 32'h0);
      chk("t5_rst_expired", 32'(expired), 32'h0);
      chk("t5_rst_warn", 32'(warn), 32'h0);

      // Low-time warning window
      preset = 8'h08;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      repeat (11) tick();
      chk("t6_at_06_warn", 32'(warn), 32'h0);
      tick();
      chk("t6_at_05", 32'(time_bcd), 32'h05);
`ifdef TIMER_WARN_EN
      chk("t6_warn_high", 32'(warn), 32'h1);
`else
      chk("t6_warn_off", 32'(warn), 32'h0);
`endif
      repeat (20) tick();
      chk("t6_expired", 32'(expired), 32'h1);
      chk("t6_warn_done", 32'(warn), 32'h0);

      // Randomized runs
      for (int r = 0; r < 40; r++) begin
         preset = {4'($urandom_range(0, 2)), 4'($urandom)};
         if ($urandom_range(0, 9) == 0) preset = 8'($urandom);
         start = 1'b1;
         tick();
         start = 1'b0;
         n = int'($urandom_range(20, 160));
         for (int c = 0; c < n; c++) begin
            abort = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 7) == 0) pause = ~pause;
            tick();
         end
         abort = 1'b0;
         start = 1'b0;
         pause = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
